// File: rtl/trace_pkg.sv
// Shared types for the register-file write-back trace buffer.
// FSM state encoding, default widths and the record layout.
package trace_pkg;

    localparam int TR_XLEN  = 32;
    localparam int TR_PC_W  = 32;
    localparam int TR_RA_W  = 5;
    localparam int TR_DEPTH = 16;
    localparam int TR_CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_e;

    // Record layout at the default widths; the top rebuilds the
    // same layout from its own parameters.
    typedef struct packed {
        logic [TR_CYC_W-1:0] cycle;
        logic [TR_RA_W-1:0]  rd;
        logic [TR_XLEN-1:0]  data;
        logic [TR_PC_W-1:0]  pc;
    } trace_rec_t;

    function automatic int rec_width(
        input int cyc_w,
        input int ra_w,
        input int xlen,
        input int pc_w
    );
        return cyc_w + ra_w + xlen + pc_w;
    endfunction

endpackage

// File: rtl/trace_ring_buf.sv
// Circular record store with show-ahead head output.
// Ports: clr/push/pop/ovw control, head/count/full/empty status.
import trace_pkg::*;

module trace_ring_buf #(
    parameter int DEPTH = TR_DEPTH,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       ovw,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;

    logic do_pop;
    logic do_wr;
    logic adv_rd;
    logic inc;
    logic dec;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    always_comb begin
        do_pop = pop && !empty;
        // When full the write slot equals the head slot, so a
        // write without a pop is only legal as an overwrite.
        do_wr  = push && (!full || do_pop || ovw);
        adv_rd = do_pop || (push && full && ovw);
        inc    = do_wr && !do_pop && !full;
        dec    = do_pop && !do_wr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr)
                wp <= wp + PW'(1);
            if (adv_rd)
                rp <= rp + PW'(1);
            if (inc)
                cnt <= cnt + CW'(1);
            else if (dec)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clr && do_wr)
            mem[wp] <= din;
    end

    assign head  = empty ? '0 : mem[rp];
    assign count = cnt;

endmodule

// File: rtl/regfile_trace_buffer.sv
// Write-back snooper capturing qualified writes into a trace ring.
// Ports: cfg_*, start, wb_* in; rd_* drain port, count/overflow/busy/done.
import trace_pkg::*;

module regfile_trace_buffer #(
    parameter int XLEN  = TR_XLEN,
    parameter int PC_W  = TR_PC_W,
    parameter int RA_W  = TR_RA_W,
    parameter int DEPTH = TR_DEPTH,
    parameter int CYC_W = TR_CYC_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2**RA_W-1:0]     cfg_mask,
    input  logic [CYC_W-1:0]       cfg_limit,
    input  logic                   cfg_ring,
    input  logic                   start,
    input  logic                   wb_en,
    input  logic [RA_W-1:0]        wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic [PC_W-1:0]        wb_pc,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [CYC_W-1:0]       rd_cycle,
    output logic [RA_W-1:0]        rd_reg,
    output logic [XLEN-1:0]        rd_data,
    output logic [PC_W-1:0]        rd_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);

    localparam int REC_W = rec_width(CYC_W, RA_W, XLEN, PC_W);

    typedef struct packed {
        logic [CYC_W-1:0] cycle;
        logic [RA_W-1:0]  rd;
        logic [XLEN-1:0]  data;
        logic [PC_W-1:0]  pc;
    } rec_t;

    trace_state_e state_q;
    trace_state_e state_d;

    logic [CYC_W-1:0] cyc_q;
    logic             ovf_q;

    rec_t             wr_rec;
    rec_t             hd_rec;
    logic [REC_W-1:0] head;

    logic qual;
    logic pop_ok;
    logic lost;
    logic drop;
    logic last;
    logic full;
    logic empty;

    always_comb begin
        qual   = busy && wb_en && (wb_rd != '0) && cfg_mask[wb_rd];
        pop_ok = rd_ready && !empty;
        lost   = qual && full && !pop_ok;
        drop   = lost && !cfg_ring;
        last   = (cfg_limit != '0) &&
                 (cyc_q == cfg_limit - CYC_W'(1));
    end

    always_comb begin
        wr_rec.cycle = cyc_q;
        wr_rec.rd    = wb_rd;
        wr_rec.data  = wb_data;
        wr_rec.pc    = wb_pc;
    end

    trace_ring_buf #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (qual),
        .pop   (rd_ready),
        .ovw   (cfg_ring),
        .din   (wr_rec),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = CAPTURE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                CAPTURE: if (last || drop) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE:    ;
            CAPTURE: busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counter holds at all-ones when the window is unlimited.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cyc_q <= '0;
        else if (start)
            cyc_q <= '0;
        else if (busy && (cyc_q != '1))
            cyc_q <= cyc_q + CYC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (start)
            ovf_q <= 1'b0;
        else if (lost)
            ovf_q <= 1'b1;
    end

    assign hd_rec   = head;
    assign rd_valid = !empty;
    assign rd_cycle = hd_rec.cycle;
    assign rd_reg   = hd_rec.rd;
    assign rd_data  = hd_rec.data;
    assign rd_pc    = hd_rec.pc;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_regfile_trace_buffer.sv
// Directed self-checking bench for regfile_trace_buffer.
// Buffer instantiated with DEPTH=4 to reach full quickly.
module tb_regfile_trace_buffer;

    localparam int XLEN  = 32;
    localparam int PC_W  = 32;
    localparam int RA_W  = 5;
    localparam int DEPTH = 4;
    localparam int CYC_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       cfg_mask;
    logic [CYC_W-1:0]  cfg_limit;
    logic              cfg_ring;
    logic              start;
    logic              wb_en;
    logic [RA_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [PC_W-1:0]   wb_pc;
    logic              rd_valid;
    logic              rd_ready;
    logic [CYC_W-1:0]  rd_cycle;
    logic [RA_W-1:0]   rd_reg;
    logic [XLEN-1:0]   rd_data;
    logic [PC_W-1:0]   rd_pc;
    logic [2:0]        count;
    logic              overflow;
    logic              busy;
    logic              done;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    regfile_trace_buffer #(
        .XLEN  (XLEN),
        .PC_W  (PC_W),
        .RA_W  (RA_W),
        .DEPTH (DEPTH),
        .CYC_W (CYC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mask  (cfg_mask),
        .cfg_limit (cfg_limit),
        .cfg_ring  (cfg_ring),
        .start     (start),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_pc     (wb_pc),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_cycle  (rd_cycle),
        .rd_reg    (rd_reg),
        .rd_data   (rd_data),
        .rd_pc     (rd_pc),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d,
                      input logic [31:0] pc);
        wb_en   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        wb_pc   = pc;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic pop1();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", overflow); end
        checks++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL rst_busy_done got %b want 00", {busy, done}); end
        checks++; if (rd_data !== 32'h0 || rd_cycle !== 16'h0) begin errs++; $display("FAIL rst_fields got %h/%h want 0/0", rd_data, rd_cycle); end
        cfg_mask = 32'hFFFF_FFFE;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        repeat (10) tick();
        wb_en = 1'b0;
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL idle_count got %0d want 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL idle_valid got %b want 0", rd_valid); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        cfg_mask  = 32'h3000_00E2;
        cfg_limit = 16'd20;
        cfg_ring  = 1'b0;
        do_start();
        checks++; if (busy !== 1'b1 || count !== 3'd0) begin errs++; $display("FAIL basic_start got busy=%b cnt=%0d want 1/0", busy, count); end
        for (int c = 0; c < 20; c++) begin
            wb_en = 1'b0;
            if (c == 1) begin wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h10; wb_pc = 32'h100; end
            if (c == 3) begin wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h99; wb_pc = 32'h108; end
            if (c == 4) begin wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h20; wb_pc = 32'h10C; end
            if (c == 6) begin wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h33; wb_pc = 32'h114; end
            if (c == 19) begin
                checks++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL basic_last got %b want 10", {busy, done}); end
            end
            tick();
        end
        wb_en = 1'b0;
        checks++; if ({busy, done} !== 2'b01) begin errs++; $display("FAIL basic_done got %b want 01", {busy, done}); end
        checks++; if (count !== 3'd2) begin errs++; $display("FAIL basic_count got %0d want 2", count); end
        wr(5'd5, 32'hDEAD, 32'h200);
        checks++; if (count !== 3'd2) begin errs++; $display("FAIL basic_done_nocap got %0d want 2", count); end
        checks++; if ({rd_valid, rd_cycle, rd_reg, rd_data, rd_pc} !== {1'b1, 16'd1, 5'd5, 32'h10, 32'h100}) begin
            errs++; $display("FAIL basic_rec0 got v=%b c=%0d r=%0d d=%h pc=%h want 1/1/5/10/100", rd_valid, rd_cycle, rd_reg, rd_data, rd_pc);
        end
        pop1();
        checks++; if ({rd_cycle, rd_reg, rd_data, rd_pc, count} !== {16'd4, 5'd7, 32'h20, 32'h10C, 3'd1}) begin
            errs++; $display("FAIL basic_rec1 got c=%0d r=%0d d=%h pc=%h n=%0d want 4/7/20/10c/1", rd_cycle, rd_reg, rd_data, rd_pc, count);
        end
        pop1();
        checks++; if ({rd_valid, count, rd_data} !== {1'b0, 3'd0, 32'h0}) begin errs++; $display("FAIL basic_empty got v=%b n=%0d d=%h want 0/0/0", rd_valid, count, rd_data); end
    endtask

    task automatic test_stop_full();
        cfg_mask  = 32'hFFFF_FFFE;
        cfg_limit = 16'd0;
        cfg_ring  = 1'b0;
        do_start();
        for (int i = 1; i <= 6; i++) begin
            wr(5'd1, 32'(i), 32'h400 + 32'(4 * i));
            if (i == 4) begin
                checks++; if ({count, overflow, busy} !== {3'd4, 1'b0, 1'b1}) begin errs++; $display("FAIL stop_4th got n=%0d o=%b b=%b want 4/0/1", count, overflow, busy); end
            end
            if (i == 5) begin
                checks++; if ({count, overflow, done} !== {3'd4, 1'b1, 1'b1}) begin errs++; $display("FAIL stop_5th got n=%0d o=%b d=%b want 4/1/1", count, overflow, done); end
            end
        end
        checks++; if (count !== 3'd4) begin errs++; $display("FAIL stop_6th got %0d want 4", count); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if ({rd_data, rd_cycle} !== {32'(i), 16'(i - 1)}) begin errs++; $display("FAIL stop_drain%0d got d=%h c=%0d want %0d/%0d", i, rd_data, rd_cycle, i, i - 1); end
            pop1();
        end
        checks++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL stop_drained got %b want 0", rd_valid); end
    endtask

    task automatic test_ring_full();
        cfg_limit = 16'd10;
        cfg_ring  = 1'b1;
        do_start();
        for (int i = 1; i <= 6; i++) wr(5'd3, 32'(i), 32'h800);
        checks++; if ({count, overflow, busy} !== {3'd4, 1'b1, 1'b1}) begin errs++; $display("FAIL ring_6th got n=%0d o=%b b=%b want 4/1/1", count, overflow, busy); end
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL ring_busy got %b want 1", busy); end
        tick();
        checks++; if ({busy, done} !== 2'b01) begin errs++; $display("FAIL ring_done got %b want 01", {busy, done}); end
        for (int i = 3; i <= 6; i++) begin
            checks++; if ({rd_data, rd_cycle} !== {32'(i), 16'(i - 1)}) begin errs++; $display("FAIL ring_drain%0d got d=%h c=%0d want %0d/%0d", i, rd_data, rd_cycle, i, i - 1); end
            pop1();
        end
    endtask

    task automatic test_full_pushpop();
        for (int m = 0; m < 2; m++) begin
            cfg_limit = 16'd0;
            cfg_ring  = m[0];
            do_start();
            for (int i = 1; i <= 4; i++) wr(5'd4, 32'h10 + 32'(i), 32'h0);
            rd_ready = 1'b1;
            wr(5'd4, 32'h15, 32'h0);
            rd_ready = 1'b0;
            checks++; if ({count, overflow, busy} !== {3'd4, 1'b0, 1'b1}) begin errs++; $display("FAIL pp%0d_state got n=%0d o=%b b=%b want 4/0/1", m, count, overflow, busy); end
            for (int i = 2; i <= 5; i++) begin
                checks++; if (rd_data !== 32'h10 + 32'(i)) begin errs++; $display("FAIL pp%0d_order got %h want %h", m, rd_data, 32'h10 + 32'(i)); end
                pop1();
            end
        end
    endtask

    task automatic test_restart();
        cfg_limit = 16'd0;
        cfg_ring  = 1'b1;
        do_start();
        for (int i = 1; i <= 5; i++) wr(5'd6, 32'hA0 + 32'(i), 32'h0);
        pop1();
        checks++; if ({count, overflow} !== {3'd3, 1'b1}) begin errs++; $display("FAIL rs_pre got n=%0d o=%b want 3/1", count, overflow); end
        start = 1'b1; rd_ready = 1'b1;
        wr(5'd6, 32'hEE, 32'h0);
        start = 1'b0; rd_ready = 1'b0;
        checks++; if ({count, overflow, rd_valid, busy} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            errs++; $display("FAIL rs_clear got n=%0d o=%b v=%b b=%b want 0/0/0/1", count, overflow, rd_valid, busy);
        end
        wr(5'd3, 32'h77, 32'h900);
        checks++; if ({count, rd_cycle, rd_data} !== {3'd1, 16'd0, 32'h77}) begin errs++; $display("FAIL rs_first got n=%0d c=%0d d=%h want 1/0/77", count, rd_cycle, rd_data); end
    endtask

    initial begin
        rst_n = 1'b0; cfg_mask = '0; cfg_limit = '0; cfg_ring = 1'b0;
        start = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
        rd_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_stop_full();
        test_ring_full();
        test_full_pushpop();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/regfile_trace_buffer.md
Name: regfile_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the pipelined CPU.
- Snoops the register-file write-back port and records qualifying writes into a parametrised circular buffer. Each record holds the cycle stamp, destination register, data and PC.
- A run is bounded by a programmable cycle limit. Two modes: stop-when-full or ring (overwrite oldest).
- Records are drained through a valid/ready read port, so simulation and FPGA runs share one register-trace mechanism.

Parameters:
- XLEN, 32, write-back data width.
- PC_W, 32, captured PC width.
- RA_W, 5, register address width (32 architectural registers).
- DEPTH, 16, buffer entries; power of two, ≥2.
- CYC_W, 16, cycle counter and cycle-limit width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_mask  in  2**RA_W  per-register capture enable; bit i enables register x_i.
- cfg_limit  in  CYC_W  capture window in cycles; 0 = unlimited.
- cfg_ring  in  1  0 = stop when full, 1 = overwrite oldest.
- start  in  1  one-cycle pulse; begins a run.
- wb_en  in  1  write-back strobe.
- wb_rd  in  RA_W  write-back destination register.
- wb_data  in  XLEN  write-back data.
- wb_pc  in  PC_W  PC of the writing instruction.
- rd_valid  out  1  head record available.
- rd_ready  in  1  consumer accepts head record.
- rd_cycle  out  CYC_W  head record cycle stamp.
- rd_reg  out  RA_W  head record register.
- rd_data  out  XLEN  head record data.
- rd_pc  out  PC_W  head record PC.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; at least one record was lost or overwritten.
- busy  out  1  state is CAPTURE.
- done  out  1  state is DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; buffer empty; count=0; rd_valid=0; overflow=0; busy=0; done=0; cycle counter=0. rd_* fields read 0 while empty.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE --start--> CAPTURE.
  - CAPTURE --limit reached, or full in stop mode--> DONE.
  - DONE --start--> CAPTURE.
- start in any state restarts the run, and takes priority over a same-cycle pop:
  - clears buffer, overflow and cycle counter;
  - the first capturable cycle is the one after start.
- cfg_* inputs are sampled every cycle. They must be held stable during CAPTURE; changing them mid-run is undefined.
- Cycle counter:
  - increments each CAPTURE cycle, starting at 0;
  - the stamp recorded is the counter value in the write-back cycle;
  - saturates at 2**CYC_W-1 when cfg_limit=0.
  - With cfg_limit=N≠0, the last capturable cycle is counter N-1. The FSM is DONE in the next cycle, and a write-back in that last cycle is still captured.
- Capture qualifier: busy && wb_en && wb_rd≠0 && cfg_mask[wb_rd]. Writes to x0 are never recorded.
- Push latency: qualified write-back at edge k → rd_valid/count reflect it after edge k. Read is show-ahead, so the head record is visible combinationally from registered buffer state.
- Pop: rd_valid && rd_ready at an edge. Popping is allowed in all states.
- Full, stop mode (cfg_ring=0):
  - a qualified push with no same-cycle pop is dropped;
  - overflow is set and state goes to DONE in the same edge.
  - Push and pop together when full: both occur, count unchanged, no overflow, stays in CAPTURE.
- Full, ring mode (cfg_ring=1):
  - push without pop overwrites the oldest entry and advances the head;
  - count stays DEPTH and overflow is set.
  - Push and pop together: the oldest is popped and the new one stored, no overflow.
- Empty with push and pop in the same cycle: rd_valid=0, so the pop is ignored and the push succeeds.
- Pointers wrap modulo DEPTH. count range is 0..DEPTH.

Decomposition:
- Package trace_pkg:
  - state enum {IDLE, CAPTURE, DONE};
  - packed struct trace_rec_t {cycle, reg, data, pc};
  - DEPTH-independent widths derived from the parameters.
- Sub-module trace_ring_buf: parametrised on DEPTH and record width. Provides push, pop, overwrite-on-full enable, head output, count, full/empty.
- The top level holds the FSM, cycle counter, qualifier and overflow logic.

Test Plan:
- Reset then idle: drive wb_en=1, wb_rd=5 for 10 cycles without start → count=0, rd_valid=0, busy=0.
- start, cfg_mask=0x3000_00E2, cfg_limit=20, cfg_ring=0. Writes at counter cycles 1/3/4 to x5=0x10, x0=0x99, x7=0x20 → 2 records {1,5,0x10}, {4,7,0x20}. done=1 after counter 19.
- DEPTH=4, stop mode, 6 qualified writes, rd_ready=0 → count=4, overflow=1, done at the 5th write. Records 1–4 are retained.
- DEPTH=4, ring mode, 6 writes (data 1..6), rd_ready=0 → count=4, overflow=1, drained data=3,4,5,6, busy stays 1 until the limit.
- Full with a simultaneous push and pop (rd_ready=1), in both modes → count stays 4, overflow=0, FIFO order preserved.
- Mid-run start while count=3 and a pop is pending → next cycle count=0, overflow=0, counter=0, state CAPTURE.
